// File: rtl/core_ecc_pkg.sv
// Shared types and helpers for the core-side Hamming sink.
//   err_t    : per-flit decode status carried alongside each FIFO entry
//   par_w    : Hamming parity width for a supported payload width (4 -> 3, 11 -> 4)
//   is_pow2  : true for Hamming parity positions (1, 2, 4, 8, ...)
//   data_pos : codeword position (1-based) of payload bit idx
package core_ecc_pkg;

  typedef enum logic [1:0] {
    ERR_CLEAN  = 2'b00,
    ERR_CORR   = 2'b01,
    ERR_UNCORR = 2'b10
  } err_t;

  function automatic int unsigned par_w(input int unsigned data_w);
    return (data_w == 11) ? 4 : 3;
  endfunction

  function automatic logic is_pow2(input int unsigned pos);
    return (pos != 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // Payload bits occupy the non-parity positions in ascending order.
  function automatic int unsigned data_pos(input int unsigned idx);
    int unsigned k;
    int unsigned res;
    k   = 0;
    res = 0;
    for (int unsigned p = 1; p < 64; p++) begin
      if (!is_pow2(p)) begin
        if (k == idx && res == 0) res = p;
        k++;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/core_ecc_fifo.sv
// Synchronous FIFO holding decoded {err, data, ip} entries.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   i_push     : write i_wdata (ignored when full)
//   i_pop      : drop the head (ignored when empty)
//   o_rdata    : current head entry, read from the storage registers
//   o_count    : number of stored entries; o_full / o_empty status
module core_ecc_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic [AW:0]      o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/core_ecc_sink.sv
// Hamming sink between the router ejection port and the core consumer.
// Decodes {codeword, ip} flits (SEC, or SECDED when SECDED=1), buffers the
// corrected {data, ip} with its status in a FIFO and keeps saturating
// corrected / uncorrectable counters.
//   in_valid/in_ready/in_flit    : flit input, accepted on valid&&ready
//   out_valid/out_ready          : FIFO head handshake
//   out_data/out_err             : head {data, ip} and status (00/01/10)
//   cnt_clr                      : synchronous clear of both counters
//   corr_cnt/uncorr_cnt          : accepted corrected / uncorrectable flits
module core_ecc_sink
  import core_ecc_pkg::*;
#(
  parameter  int unsigned DATA_W      = 4,
  parameter  int unsigned IP_W        = 4,
  parameter  int unsigned SECDED      = 0,
  parameter  int unsigned DEPTH       = 4,
  parameter  int unsigned DROP_UNCORR = 1,
  parameter  int unsigned CNT_W       = 16,
  localparam int unsigned PAR_W       = par_w(DATA_W),
  localparam int unsigned N           = DATA_W + PAR_W,
  localparam int unsigned CW_W        = N + SECDED
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CW_W+IP_W-1:0]   in_flit,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W+IP_W-1:0] out_data,
  output logic [1:0]             out_err,
  input  logic                   cnt_clr,
  output logic [CNT_W-1:0]       corr_cnt,
  output logic [CNT_W-1:0]       uncorr_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned EW = 2 + DATA_W + IP_W;

  logic [CW_W-1:0]   w_cw;
  logic [IP_W-1:0]   w_ip;
  logic [PAR_W-1:0]  w_syn;
  logic              w_po;
  logic              w_flip;
  logic [N-1:0]      w_fix;
  logic [DATA_W-1:0] w_data;
  err_t              w_err;

  logic              w_accept;
  logic              w_drop;
  logic              w_push;
  logic              w_pop;
  logic [EW-1:0]     w_rdata;
  logic [AW:0]       w_count;
  logic              w_full;
  logic              w_empty;

  logic              r_run;
  logic [CNT_W-1:0]  r_corr;
  logic [CNT_W-1:0]  r_uncorr;

  assign w_cw = in_flit[CW_W+IP_W-1 -: CW_W];
  assign w_ip = in_flit[IP_W-1:0];

  always_comb begin
    w_syn = '0;
    for (int unsigned p = 1; p <= N; p++) begin
      if (w_cw[p-1]) w_syn ^= PAR_W'(p);
    end
    w_po = (SECDED != 0) ? ^w_cw : 1'b0;

    w_flip = 1'b0;
    w_err  = ERR_CLEAN;
    if (SECDED == 0) begin
      if (w_syn != '0) begin
        w_flip = 1'b1;
        w_err  = ERR_CORR;
      end
    end else if (w_po) begin
      // Zero syndrome with odd parity means only the overall bit was hit.
      w_flip = (w_syn != '0);
      w_err  = ERR_CORR;
    end else if (w_syn != '0) begin
      w_err = ERR_UNCORR;
    end

    w_fix = w_cw[N-1:0];
    for (int unsigned p = 1; p <= N; p++) begin
      if (w_flip && (w_syn == PAR_W'(p))) w_fix[p-1] = ~w_fix[p-1];
    end

    w_data = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      w_data[i] = w_fix[data_pos(i) - 1];
    end
  end

  // Ready is held low through reset and the first edge after release.
  assign in_ready  = r_run && (w_count < (AW+1)'(DEPTH));
  assign w_accept  = in_valid && in_ready;
  assign w_drop    = (DROP_UNCORR != 0) && (w_err == ERR_UNCORR);
  assign w_push    = w_accept && !w_drop && !w_full;
  assign w_pop     = out_ready && !w_empty;
  assign out_valid = !w_empty;
  assign out_err   = w_rdata[EW-1 -: 2];
  assign out_data  = w_rdata[DATA_W+IP_W-1:0];

  core_ecc_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata ({w_err, w_data, w_ip}),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run    <= 1'b0;
      r_corr   <= '0;
      r_uncorr <= '0;
    end else begin
      r_run <= 1'b1;
      if (cnt_clr) begin
        r_corr   <= '0;
        r_uncorr <= '0;
      end else begin
        if (w_accept && (w_err == ERR_CORR) && (r_corr != '1))
          r_corr <= r_corr + CNT_W'(1);
        if (w_accept && (w_err == ERR_UNCORR) && (r_uncorr != '1))
          r_uncorr <= r_uncorr + CNT_W'(1);
      end
    end
  end

  assign corr_cnt   = r_corr;
  assign uncorr_cnt = r_uncorr;

endmodule

// File: doc/core_ecc_sink.md
# core_ecc_sink

Clocked, parametrised Hamming sink for the NoC core side. It accepts router flits of the form | codeword | IP | and corrects single-bit errors; with SECDED enabled it also detects double-bit errors. It buffers the decoded | data | IP | words in a small FIFO for the data bucket and keeps saturating error statistics. It succeeds the fixed 7-bit, unbuffered core data bucket and sits between the router ejection port and the core's consumer.

## Interface
- DATA_W, 4, payload bits per flit; legal values are 4 and 11 only. PAR_W is derived: 3 for 4, 4 for 11. N = DATA_W+PAR_W.
- IP_W, 4, source-IP field width.
- SECDED, 0, 1 appends an overall parity bit as the codeword MSB. CW_W = N+SECDED.
- DEPTH, 4, output FIFO entries; power of two, ≥2.
- DROP_UNCORR, 1, 1 discards uncorrectable flits; 0 forwards them with an error flag.
- CNT_W, 16, width of the error counters.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  flit offered.
- in_ready  out  1  flit accepted on the clk edge where in_valid&&in_ready.
- in_flit  in  CW_W+IP_W  {codeword, ip}. Codeword bit i is Hamming position i+1.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer pops the head on the edge where out_valid&&out_ready.
- out_data  out  DATA_W+IP_W  {corrected data, ip}.
- out_err  out  2  status of the head: 00 clean, 01 corrected, 10 uncorrectable.
- cnt_clr  in  1  synchronous clear of both counters.
- corr_cnt  out  CNT_W  number of corrected flits accepted.
- uncorr_cnt  out  CNT_W  number of uncorrectable flits accepted.

## Operation
- Decode is combinational on in_flit. The FIFO write occurs on the accept edge.
- Syndrome s: bit j is the XOR of all positions p (1..N) with p[j]=1.
- Overall parity po (SECDED only) is the XOR of all CW_W bits.
- SECDED=0:
  - s=0 → clean.
  - s≠0 → flip position s, then corrected.
- SECDED=1:
  - s=0, po=0 → clean.
  - po=1, s=0 → overall bit in error; data is intact; corrected.
  - po=1, s≠0 → flip position s; corrected.
  - s≠0, po=0 → uncorrectable; data is passed uncorrected.
- Data extraction: the non-power-of-two positions in ascending order map to data[0] upward. For DATA_W=4, data = {pos7,pos6,pos5,pos3}.
- Uncorrectable flit with DROP_UNCORR=1: it is accepted, counted and not written to the FIFO.
- Counters saturate at all-ones. When cnt_clr and an increment occur on the same edge, clear wins and the result is 0.
- Backpressure: in_ready = (count < DEPTH). It does not depend on out_ready, so there is no same-cycle pass-through when the FIFO is full.
- A simultaneous push and pop on a non-full FIFO leaves count unchanged and keeps order. Pointers wrap modulo DEPTH.

## Timing
- Reset (asynchronous assert; deassert is taken at the next clk edge):
  - FIFO empty, pointers 0.
  - out_valid=0, out_data=0, out_err=00.
  - corr_cnt=0, uncorr_cnt=0.
  - in_ready=0 while rst_n=0; in_ready=1 in the first cycle after release.
- Latency: a flit accepted at edge k into an empty FIFO shows out_valid=1 after edge k, i.e. in cycle k+1.
- out_data and out_err are registered FIFO outputs. They hold stable while out_valid&&!out_ready.
- Counters update on the accept edge, so they are visible one cycle after the flit is accepted.
- Reset mid-operation discards all buffered flits. No partial output is produced.

## Structure
- Package core_ecc_pkg holds:
  - the err_t enum {ERR_CLEAN, ERR_CORR, ERR_UNCORR};
  - function par_w(DATA_W);
  - function is_pow2(pos), used for data-position extraction.
- Sub-module core_ecc_fifo: parametrised synchronous FIFO (WIDTH, DEPTH) with count, full and empty outputs. Its entry is {err_t, data, ip}.
- The decoder stays inline in core_ecc_sink as an always_comb block.

## Test plan
- DATA_W=4, SECDED=0: in_flit=11'h55A (data 4'hB, IP 4'hA) → out_data=8'hBA, out_err=00 one cycle later, counters unchanged.
- Same flit with bit 4 flipped, 11'h45A → out_data=8'hBA, out_err=01, corr_cnt=1.
- SECDED=1, DROP_UNCORR=1: 12'h56A (bits 0 and 1 of 8'h55 flipped) → no output, uncorr_cnt=1. With DROP_UNCORR=0 the same flit yields out_err=10.
- DEPTH=4, out_ready=0: push 4 clean flits → in_ready=0 after the 4th; a 5th flit is held. Raise out_ready → the flits drain in order and in_ready returns to 1.
- Preload corr_cnt to all-ones via repeated corrected flits at CNT_W=4 → it stays 4'hF. cnt_clr asserted together with a corrected flit → 0.
- Assert rst_n=0 with 2 flits buffered → out_valid=0 immediately and the counters read 0.
